// File: rtl/ibex_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package ibex_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned RegDataW = 32;

    typedef enum logic {
        ARB_DRAIN   = 1'b0,
        ARB_STARVED = 1'b1
    } rf_wport_arb_state_e;

endpackage

// File: rtl/ibex_rf_aux_queue.sv
// Auxiliary write queue: FIFO storage with per-entry live bits,
// squash-on-core-write and read-address hazard detection.
module ibex_rf_aux_queue
    import ibex_pkg::*;
#(
    parameter int unsigned AuxDepth = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [RegAddrW-1:0] push_waddr,
    input  logic [RegDataW-1:0] push_wdata,
    input  logic                pop,
    input  logic                squash,
    input  logic [RegAddrW-1:0] squash_addr,
    input  logic [RegAddrW-1:0] raddr_a,
    input  logic [RegAddrW-1:0] raddr_b,
    output logic                head_live,
    output logic [RegAddrW-1:0] head_waddr,
    output logic [RegDataW-1:0] head_wdata,
    output logic                empty,
    output logic                full,
    output logic                any_live,
    output logic                hazard
);

    localparam int unsigned PtrW = $clog2(AuxDepth);
    localparam int unsigned CntW = PtrW + 1;

    logic [RegAddrW-1:0] waddr_q [AuxDepth];
    logic [RegDataW-1:0] wdata_q [AuxDepth];
    logic [AuxDepth-1:0] live_q;
    logic [PtrW-1:0]     wptr_q;
    logic [PtrW-1:0]     rptr_q;
    logic [CntW-1:0]     count_q;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(AuxDepth));
    assign head_live  = live_q[rptr_q];
    assign head_waddr = waddr_q[rptr_q];
    assign head_wdata = wdata_q[rptr_q];
    // A popped slot always has its live bit cleared, so live implies occupied.
    assign any_live   = |live_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at AuxDepth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage and live bits: squash first, then pop clear, then push
    // so a same-cycle push to a matching address stays live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
            for (int unsigned i = 0; i < AuxDepth; i++) begin
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            if (squash) begin
                for (int unsigned i = 0; i < AuxDepth; i++) begin
                    if (live_q[i] && (waddr_q[i] == squash_addr)) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                live_q[rptr_q] <= 1'b0;
            end
            if (push) begin
                live_q[wptr_q]  <= 1'b1;
                waddr_q[wptr_q] <= push_waddr;
                wdata_q[wptr_q] <= push_wdata;
            end
        end
    end

    // Hazard: any live, non-x0 entry matching either ID read address.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < AuxDepth; i++) begin
            if (live_q[i] && (waddr_q[i] != '0) &&
                ((waddr_q[i] == raddr_a) || (waddr_q[i] == raddr_b))) begin
                hazard = 1'b1;
            end
        end
    end

    property p_no_push_full;
        @(posedge clk) disable iff (!rst_n) !(push && full);
    endproperty
    a_no_push_full: assert property (p_no_push_full);

endmodule

// File: rtl/ibex_rf_wport_arb.sv
// Register-file write-port arbiter: core always wins, queued auxiliary
// writes fill idle cycles, starvation raises a stall request.
module ibex_rf_wport_arb
    import ibex_pkg::*;
#(
    parameter int unsigned AuxDepth    = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                core_we_i,
    input  logic [RegAddrW-1:0] core_waddr_i,
    input  logic [RegDataW-1:0] core_wdata_i,
    input  logic                aux_valid_i,
    output logic                aux_ready_o,
    input  logic [RegAddrW-1:0] aux_waddr_i,
    input  logic [RegDataW-1:0] aux_wdata_i,
    input  logic [RegAddrW-1:0] rf_raddr_a_i,
    input  logic [RegAddrW-1:0] rf_raddr_b_i,
    output logic                aux_hazard_o,
    output logic                stall_req_o,
    output logic                rf_we_o,
    output logic [RegAddrW-1:0] rf_waddr_o,
    output logic [RegDataW-1:0] rf_wdata_o,
    output logic                aux_retire_o
);

    localparam int unsigned CntW = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

    logic                push;
    logic                pop;
    logic                aux_write;
    logic                head_live;
    logic [RegAddrW-1:0] head_waddr;
    logic [RegDataW-1:0] head_wdata;
    logic                q_empty;
    logic                q_full;
    logic                q_any_live;

    logic [CntW-1:0]     starve_cnt_q;
    logic [CntW-1:0]     starve_cnt_d;
    rf_wport_arb_state_e state_q;
    rf_wport_arb_state_e state_d;

    assign aux_ready_o  = ~q_full;
    assign push         = aux_valid_i & ~q_full;
    assign pop          = ~core_we_i & ~q_empty;
    assign aux_write    = pop & head_live & (head_waddr != '0);
    assign aux_retire_o = pop;

    ibex_rf_aux_queue #(
        .AuxDepth (AuxDepth)
    ) u_aux_queue (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .push        (push),
        .push_waddr  (aux_waddr_i),
        .push_wdata  (aux_wdata_i),
        .pop         (pop),
        .squash      (core_we_i),
        .squash_addr (core_waddr_i),
        .raddr_a     (rf_raddr_a_i),
        .raddr_b     (rf_raddr_b_i),
        .head_live   (head_live),
        .head_waddr  (head_waddr),
        .head_wdata  (head_wdata),
        .empty       (q_empty),
        .full        (q_full),
        .any_live    (q_any_live),
        .hazard      (aux_hazard_o)
    );

    // Write-port mux: core pass-through has priority over the queue head.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (core_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end else if (aux_write) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head_waddr;
            rf_wdata_o = head_wdata;
        end
    end

    // Starvation count: a queue holding only squashed entries counts as
    // empty, so dead entries never cause a stall.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || !q_any_live) begin
            starve_cnt_d = '0;
        end else if (core_we_i && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_DRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: starve on limit, release on pop or no live entries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_DRAIN: begin
                if (starve_cnt_d == StarveMax) begin
                    state_d = ARB_STARVED;
                end
            end
            ARB_STARVED: begin
                if (pop || !q_any_live) begin
                    state_d = ARB_DRAIN;
                end
            end
            default: state_d = ARB_DRAIN;
        endcase
    end

    // FSM output: stall request decoded straight from the state register.
    always_comb begin
        stall_req_o = (state_q == ARB_STARVED);
    end

    property p_no_aux_over_core;
        @(posedge clk_i) disable iff (!rst_ni) !(core_we_i && aux_write);
    endproperty
    a_no_aux_over_core: assert property (p_no_aux_over_core);

    property p_starve_bound;
        @(posedge clk_i) disable iff (!rst_ni) starve_cnt_q <= StarveMax;
    endproperty
    a_starve_bound: assert property (p_starve_bound);

endmodule
